// File: rtl/t06_lcd_bus_arbiter.sv
// Grants the shared 8-bit LCD write bus to one of three requesters a byte at a time and
// generates the CS/DC/WR timing. The req to ack latency is SETUP_CYC+WR_LOW_CYC+WR_HIGH_CYC+1 cycles, and req is held off until the ack.
module t06_lcd_bus_arbiter #(
    parameter int SETUP_CYC   = 1,
    parameter int WR_LOW_CYC  = 2,
    parameter int WR_HIGH_CYC = 2
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        sync_reset,
    input  logic [2:0]  req,
    input  logic [2:0]  dc_in,
    input  logic [23:0] data_in,
    output logic [2:0]  grant,
    output logic [2:0]  ack,
    output logic        busy,
    output logic [7:0]  lcd_data,
    output logic        lcd_dc,
    output logic        lcd_wr_n,
    output logic        lcd_cs_n
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        ACK
    } state_t;

    localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
    localparam logic [3:0] LOW_LD   = 4'(WR_LOW_CYC - 1);
    localparam logic [3:0] HIGH_LD  = 4'(WR_HIGH_CYC - 1);

    state_t     state;
    logic [3:0] cnt;
    // Round-robin pointer between requesters 1 and 2: 0 favours 1, 1 favours 2.
    logic       ptr;

    logic [2:0] win;
    logic [7:0] win_data;
    logic       win_dc;

    always_comb begin
        win = 3'b000;
        if (req[0])
            win = 3'b001;
        else if (req[1] && req[2])
            win = ptr ? 3'b100 : 3'b010;
        else if (req[1])
            win = 3'b010;
        else if (req[2])
            win = 3'b100;
    end

    always_comb begin
        win_data = 8'h00;
        win_dc   = 1'b0;
        case (win)
            3'b001:  begin win_data = data_in[7:0];   win_dc = dc_in[0]; end
            3'b010:  begin win_data = data_in[15:8];  win_dc = dc_in[1]; end
            3'b100:  begin win_data = data_in[23:16]; win_dc = dc_in[2]; end
            default: begin win_data = 8'h00;          win_dc = 1'b0;     end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            ptr      <= 1'b0;
            grant    <= 3'b000;
            ack      <= 3'b000;
            busy     <= 1'b0;
            lcd_data <= 8'h00;
            lcd_dc   <= 1'b0;
            lcd_wr_n <= 1'b1;
            lcd_cs_n <= 1'b1;
        end else if (sync_reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            ptr      <= 1'b0;
            grant    <= 3'b000;
            ack      <= 3'b000;
            busy     <= 1'b0;
            lcd_data <= 8'h00;
            lcd_dc   <= 1'b0;
            lcd_wr_n <= 1'b1;
            lcd_cs_n <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (win != 3'b000) begin
                        state    <= SETUP;
                        cnt      <= SETUP_LD;
                        grant    <= win;
                        busy     <= 1'b1;
                        lcd_data <= win_data;
                        lcd_dc   <= win_dc;
                        lcd_cs_n <= 1'b0;
                    end
                end
                SETUP: begin
                    if (cnt == 4'd0) begin
                        state    <= STROBE;
                        cnt      <= LOW_LD;
                        lcd_wr_n <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                STROBE: begin
                    if (cnt == 4'd0) begin
                        state    <= HOLD;
                        cnt      <= HIGH_LD;
                        lcd_wr_n <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (cnt == 4'd0) begin
                        state <= ACK;
                        ack   <= grant;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ACK: begin
                    // The pointer moves away from the requester that was just served; init leaves it alone.
                    if (grant[1])
                        ptr <= 1'b1;
                    else if (grant[2])
                        ptr <= 1'b0;
                    state    <= IDLE;
                    ack      <= 3'b000;
                    grant    <= 3'b000;
                    busy     <= 1'b0;
                    lcd_cs_n <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    ack      <= 3'b000;
                    grant    <= 3'b000;
                    busy     <= 1'b0;
                    lcd_wr_n <= 1'b1;
                    lcd_cs_n <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_t06_lcd_bus_arbiter.sv
// Directed bench for t06_lcd_bus_arbiter: default-timing instance plus a 2/4/1 timing instance.
module tb_t06_lcd_bus_arbiter;

    logic        clk = 1'b0;
    logic        nrst;
    logic        sync_reset;
    logic [2:0]  req;
    logic [2:0]  req_b;
    logic [2:0]  dc_in;
    logic [23:0] data_in;
    logic [2:0]  grant, ack, grant_b, ack_b;
    logic        busy, busy_b;
    logic [7:0]  lcd_data, lcd_data_b;
    logic        lcd_dc, lcd_wr_n, lcd_cs_n;
    logic        lcd_dc_b, lcd_wr_n_b, lcd_cs_n_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    t06_lcd_bus_arbiter dut (
        .clk(clk), .nrst(nrst), .sync_reset(sync_reset), .req(req), .dc_in(dc_in),
        .data_in(data_in), .grant(grant), .ack(ack), .busy(busy), .lcd_data(lcd_data),
        .lcd_dc(lcd_dc), .lcd_wr_n(lcd_wr_n), .lcd_cs_n(lcd_cs_n)
    );

    t06_lcd_bus_arbiter #(.SETUP_CYC(2), .WR_LOW_CYC(4), .WR_HIGH_CYC(1)) dut_b (
        .clk(clk), .nrst(nrst), .sync_reset(sync_reset), .req(req_b), .dc_in(dc_in),
        .data_in(data_in), .grant(grant_b), .ack(ack_b), .busy(busy_b), .lcd_data(lcd_data_b),
        .lcd_dc(lcd_dc_b), .lcd_wr_n(lcd_wr_n_b), .lcd_cs_n(lcd_cs_n_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until ack on the default instance; cyc stays -1 if none arrives.
    task automatic wait_ack(output int cyc, output logic [2:0] a);
        cyc = -1;
        a   = 3'b000;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (ack != 3'b000) begin
                cyc = i;
                a   = ack;
                break;
            end
        end
    endtask

    initial begin
        int         cyc;
        logic [2:0] a;
        logic [6:0] csv, wrv, ackv;
        int         n_ack;
        logic [2:0] ack_seen;
        logic [7:0] data_at_ack;
        int         lowcnt, first, second;

        nrst = 1'b0; sync_reset = 1'b0; req = 3'b000; req_b = 3'b000;
        dc_in = 3'b000; data_in = 24'h0;
        repeat (3) tick();
        chk("rst_grant", {29'd0, grant}, 32'd0);
        chk("rst_ack", {29'd0, ack}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_data", {24'd0, lcd_data}, 32'd0);
        chk("rst_dc", {31'd0, lcd_dc}, 32'd0);
        chk("rst_wr_n", {31'd0, lcd_wr_n}, 32'd1);
        chk("rst_cs_n", {31'd0, lcd_cs_n}, 32'd1);
        chk("rst_b_cs_n", {31'd0, lcd_cs_n_b}, 32'd1);
        nrst = 1'b1;
        tick();

        // Single init command byte, per-cycle strobe shape.
        data_in[7:0] = 8'h2A; dc_in[0] = 1'b0; req = 3'b001;
        for (int c = 1; c <= 7; c++) begin
            tick();
            csv[c-1]  = lcd_cs_n;
            wrv[c-1]  = lcd_wr_n;
            ackv[c-1] = ack[0];
            if (c == 3) chk("t1_data_mid", {24'd0, lcd_data}, 32'h2A);
            if (c == 6) req = 3'b000;
        end
        chk("t1_cs_n_shape", {25'd0, csv}, {25'd0, 7'b1000000});
        chk("t1_wr_n_shape", {25'd0, wrv}, {25'd0, 7'b1111001});
        chk("t1_ack_shape", {25'd0, ackv}, {25'd0, 7'b0100000});
        chk("t1_data_end", {24'd0, lcd_data}, 32'h2A);
        chk("t1_dc_end", {31'd0, lcd_dc}, 32'd0);

        // All three requesting: init first, then 1 and 2 alternate.
        data_in = 24'h332211; dc_in = 3'b101; req = 3'b111;
        wait_ack(cyc, a);
        chk("t2_first_cyc", cyc, 32'd6);
        chk("t2_first_ack", {29'd0, a}, 32'b001);
        chk("t2_first_data", {24'd0, lcd_data}, 32'h11);
        chk("t2_first_dc", {31'd0, lcd_dc}, 32'd1);
        chk("t2_grant_at_ack", {29'd0, grant}, 32'b001);
        chk("t2_busy_at_ack", {31'd0, busy}, 32'd1);
        req = 3'b110;
        wait_ack(cyc, a);
        chk("t2_second_cyc", cyc, 32'd7);
        chk("t2_second_ack", {29'd0, a}, 32'b010);
        chk("t2_second_data", {24'd0, lcd_data}, 32'h22);
        chk("t2_second_dc", {31'd0, lcd_dc}, 32'd0);
        wait_ack(cyc, a);
        chk("t2_third_cyc", cyc, 32'd7);
        chk("t2_third_ack", {29'd0, a}, 32'b100);
        chk("t2_third_data", {24'd0, lcd_data}, 32'h33);
        wait_ack(cyc, a);
        chk("t2_fourth_cyc", cyc, 32'd7);
        chk("t2_fourth_ack", {29'd0, a}, 32'b010);
        req = 3'b000;
        tick();

        // Requester 2 arrives mid-strobe; requester 1 finishes, then pointer hands over to 2.
        data_in[15:8] = 8'h44; req = 3'b010;
        tick(); tick();
        chk("t3_strobe_low", {31'd0, lcd_wr_n}, 32'd0);
        req = 3'b110;
        wait_ack(cyc, a);
        chk("t3_ack1_cyc", cyc, 32'd4);
        chk("t3_ack1", {29'd0, a}, 32'b010);
        chk("t3_ack1_data", {24'd0, lcd_data}, 32'h44);
        wait_ack(cyc, a);
        chk("t3_ack2_cyc", cyc, 32'd7);
        chk("t3_ack2", {29'd0, a}, 32'b100);
        req = 3'b000;
        tick();

        // Input changes during HOLD are ignored.
        data_in[15:8] = 8'h55; req = 3'b010;
        repeat (4) tick();
        req = 3'b000; data_in[15:8] = 8'hAA;
        n_ack = 0; ack_seen = 3'b000; data_at_ack = 8'h00;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ack != 3'b000) begin
                n_ack++;
                ack_seen    = ack;
                data_at_ack = lcd_data;
            end
        end
        chk("t4_ack_count", n_ack, 32'd1);
        chk("t4_ack_which", {29'd0, ack_seen}, 32'b010);
        chk("t4_data_at_ack", {24'd0, data_at_ack}, 32'h55);
        chk("t4_idle_busy", {31'd0, busy}, 32'd0);

        // sync_reset mid-strobe aborts and resets the pointer.
        data_in = 24'h332211; req = 3'b110;
        tick();
        chk("t5_grant_ptr2", {29'd0, grant}, 32'b100);
        tick();
        chk("t5_in_strobe", {31'd0, lcd_wr_n}, 32'd0);
        sync_reset = 1'b1;
        tick();
        sync_reset = 1'b0;
        chk("t5_wr_n", {31'd0, lcd_wr_n}, 32'd1);
        chk("t5_cs_n", {31'd0, lcd_cs_n}, 32'd1);
        chk("t5_grant", {29'd0, grant}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_ack", {29'd0, ack}, 32'd0);
        chk("t5_data", {24'd0, lcd_data}, 32'd0);
        wait_ack(cyc, a);
        chk("t5_regrant_cyc", cyc, 32'd6);
        chk("t5_regrant_ack", {29'd0, a}, 32'b010);
        chk("t5_regrant_data", {24'd0, lcd_data}, 32'h22);
        req = 3'b000;
        tick();
        req = 3'b001; sync_reset = 1'b1;
        tick();
        chk("t5_sync_beats_grant_busy", {31'd0, busy}, 32'd0);
        chk("t5_sync_beats_grant_cs", {31'd0, lcd_cs_n}, 32'd1);
        req = 3'b000; sync_reset = 1'b0;
        tick();

        // Non-default timing instance.
        data_in[23:16] = 8'h66; req_b = 3'b100;
        lowcnt = 0; first = 0; second = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (lcd_wr_n_b == 1'b0 && first == 0) lowcnt++;
            if (ack_b != 3'b000) begin
                if (first == 0) first = i;
                else if (second == 0) second = i;
            end
        end
        req_b = 3'b000;
        chk("t6_low_cycles", lowcnt, 32'd4);
        chk("t6_first_ack", first, 32'd8);
        chk("t6_period", second - first, 32'd9);
        chk("t6_data", {24'd0, lcd_data_b}, 32'h66);
        repeat (10) tick();

        // Asynchronous reset mid-strobe releases the strobe and select at once.
        req = 3'b001;
        tick(); tick();
        chk("t7_pre_wr_n", {31'd0, lcd_wr_n}, 32'd0);
        #2 nrst = 1'b0;
        #1;
        chk("t7_async_wr_n", {31'd0, lcd_wr_n}, 32'd1);
        chk("t7_async_cs_n", {31'd0, lcd_cs_n}, 32'd1);
        chk("t7_async_grant", {29'd0, grant}, 32'd0);
        @(negedge clk);
        nrst = 1'b1; req = 3'b000;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
